// File: rtl/ch_unit_pkg.sv
// Channel-unit shared definitions.
// FSM state encoding and default datapath sizes.
package ch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CH_DATA_W = 16;
  localparam int CH_RD_LAT = 2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Registered first-word-fall-through FIFO.
// Head entry is visible on rdata_o whenever empty_o is low.
module sync_fifo_fwft #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/playback_sample_streamer.sv
// Captures RAM read data on delayed playback ticks into a sample stream.
// Optional DAC_OFFSET_BINARY_EN flips the output MSB (offset binary).
module playback_sample_streamer
  import ch_unit_pkg::*;
#(
  parameter int DATA_W     = CH_DATA_W,
  parameter int RD_LAT     = CH_RD_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              playback_en,
  input  logic              playback_tick,
  input  logic              playback_done,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_status,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e             state_q, state_d;
  logic [RD_LAT-1:0]  tick_q, tick_d;
  logic [RD_LAT-1:0]  last_q, last_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run, flush;
  logic               pipe_empty;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [DATA_W:0]    fifo_rdata;
  logic [DATA_W-1:0]  head;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (playback_en && !playback_done) state_d = ST_RUN;
      ST_RUN:
        if (playback_done || !playback_en) state_d = ST_DRAIN;
      ST_DRAIN:
        if (pipe_empty && fifo_empty) state_d = ST_DONE;
      ST_DONE:
        if (!playback_en) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    run   = (state_q == ST_RUN);
    flush = (state_q == ST_IDLE);
  end

  // Tick/last pair travels with the RAM read latency.
  always_comb begin
    tick_d[0] = playback_tick && run;
    last_d[0] = playback_done;
    for (int i = 1; i < RD_LAT; i++) begin
      tick_d[i] = tick_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_q <= '0;
      last_q <= '0;
    end else begin
      tick_q <= tick_d;
      last_q <= last_d;
    end
  end

  assign pipe_empty = (tick_q == '0);
  assign fifo_push  = tick_q[RD_LAT-1] && !flush;
  assign fifo_pop   = m_tvalid && m_tready;

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({last_q[RD_LAT-1], ram_rd_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tlast  = m_tvalid && fifo_rdata[DATA_W];
  assign head     = m_tvalid ? fifo_rdata[DATA_W-1:0] : '0;

`ifdef DAC_OFFSET_BINARY_EN
  assign m_tdata = {~head[DATA_W-1], head[DATA_W-2:0]};
`else
  assign m_tdata = head;
`endif

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    cnt_d = cnt_q;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (run && m_tready && fifo_empty && pipe_empty) unf_d = 1'b1;
    if (fifo_pop && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
    if (clr_status) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      cnt_q <= cnt_d;
    end
  end

  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_playback_sample_streamer.sv
// Random + directed bench for playback_sample_streamer.
// Scoreboard model built from queues of scheduled captures and buffered samples.
module tb_playback_sample_streamer;

  localparam int DW = 16;
  localparam int RL = 2;
  localparam int FD = 8;
  localparam int CW = 6;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          playback_en;
  logic          playback_tick;
  logic          playback_done;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          overflow;
  logic          underflow;
  logic          clr_status;
  logic [CW-1:0] sample_cnt;
  logic          busy;

  always #5 i_clk = ~i_clk;

  playback_sample_streamer #(
    .DATA_W     (DW),
    .RD_LAT     (RL),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .playback_en   (playback_en),
    .playback_tick (playback_tick),
    .playback_done (playback_done),
    .ram_rd_data   (ram_rd_data),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_status    (clr_status),
    .sample_cnt    (sample_cnt),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    return {~s[DW-1], s[DW-2:0]};
`else
    return s;
`endif
  endfunction

  // Model: 0 idle, 1 run, 2 drain, 3 done
  int            cyc;
  int            mst;
  int            due_q[$];
  bit            lst_q[$];
  logic [DW:0]   fq[$];
  bit            m_ovf, m_unf;
  int            m_cnt;

  task automatic step(input logic en, input logic tk, input logic dn,
                      input logic [DW-1:0] d, input logic rdy,
                      input logic cl, input logic rs);
    logic [DW:0] hd;
    bit v, pop, push, pe, fe, full;
    playback_en   = en;
    playback_tick = tk;
    playback_done = dn;
    ram_rd_data   = d;
    m_tready      = rdy;
    clr_status    = cl;
    i_reset       = rs;
    v  = fq.size() > 0;
    hd = v ? fq[0] : '0;
    chk("tvalid", 32'(m_tvalid), 32'(v));
    if (v) begin
      chk("tdata", 32'(m_tdata), 32'(conv(hd[DW-1:0])));
      chk("tlast", 32'(m_tlast), 32'(hd[DW]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(mst != 0));
    if (rs) begin
      mst = 0;
      due_q.delete();
      lst_q.delete();
      fq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_cnt = 0;
    end else begin
      pop  = v && rdy;
      push = due_q.size() > 0 && due_q[0] == cyc;
      pe   = due_q.size() == 0;
      fe   = fq.size() == 0;
      full = fq.size() == FD;
      if (pop) void'(fq.pop_front());
      if (push) begin
        if (!full || pop) fq.push_back({lst_q[0], d});
        void'(due_q.pop_front());
        void'(lst_q.pop_front());
      end
      if (mst == 1 && tk) begin
        due_q.push_back(cyc + RL);
        lst_q.push_back(dn);
      end
      if (cl) begin
        m_ovf = 0;
        m_unf = 0;
        m_cnt = 0;
      end else begin
        if (push && full && !pop) m_ovf = 1;
        if (mst == 1 && rdy && fe && pe) m_unf = 1;
        if (pop && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      case (mst)
        0: if (en && !dn) mst = 1;
        1: if (dn || !en) mst = 2;
        2: if (pe && fe) mst = 3;
        default: if (!en) mst = 0;
      endcase
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  logic en_r, dn_r;
  int   rb;

  initial begin
    i_reset = 1'b1;
    playback_en = 1'b0;
    playback_tick = 1'b0;
    playback_done = 1'b0;
    ram_rd_data = '0;
    m_tready = 1'b0;
    clr_status = 1'b0;
    cyc = 0;
    mst = 0;
    m_ovf = 0;
    m_unf = 0;
    m_cnt = 0;
    @(posedge i_clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", 32'(m_tdata), 32'(conv(16'h0000)));
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);

    // Basic latency: tick -> tvalid after RD_LAT+1 clocks
    step(0, 0, 0, 16'h0, 1, 0, 0);
    step(1, 0, 0, 16'h0, 1, 0, 0);
    step(1, 1, 0, 16'h0, 1, 0, 0);
    step(1, 0, 0, 16'h1234, 1, 0, 0);
    chk("lat_early", 32'(m_tvalid), 0);
    step(1, 0, 0, 16'h1234, 1, 0, 0);
    chk("lat_tvalid", 32'(m_tvalid), 1);
    chk("lat_tdata", 32'(m_tdata), 32'(conv(16'h1234)));
    chk("lat_unf", 32'(underflow), 1);
    // Clear while a pop happens: increment lost
    step(1, 0, 0, 16'h0, 1, 1, 0);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_cnt", 32'(sample_cnt), 0);

    // Backpressure and overflow
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 16'(16'h100 + i), 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 16'(16'h100 + 10 + i), 0, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 16'h0, 1, 0, 0);
    chk("ovf_drained", 32'(sample_cnt), 8);

    // End of playback on the 5th tick
    step(1, 0, 0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 1'(i == 4), 16'(16'h200 + i), 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, 16'(16'h205 + i), 1, 0, 0);
    chk("eop_cnt", 32'(sample_cnt), 5);
    chk("eop_busy", 32'(busy), 1);
    step(0, 0, 1, 16'h0, 1, 0, 0);
    chk("eop_idle", 32'(busy), 0);

    // Offset-binary output path
    step(1, 0, 0, 16'h0, 0, 0, 0);
    step(1, 1, 0, 16'h0, 0, 0, 0);
    step(1, 1, 0, 16'h0, 0, 0, 0);
    step(1, 0, 0, 16'h8000, 0, 0, 0);
    step(1, 0, 0, 16'h7FFF, 0, 0, 0);
`ifdef DAC_OFFSET_BINARY_EN
    chk("dac_8000", 32'(m_tdata), 32'h0000);
`else
    chk("dac_8000", 32'(m_tdata), 32'h8000);
`endif
    step(1, 0, 0, 16'h0, 1, 0, 0);
`ifdef DAC_OFFSET_BINARY_EN
    chk("dac_7fff", 32'(m_tdata), 32'hFFFF);
`else
    chk("dac_7fff", 32'(m_tdata), 32'h7FFF);
`endif

    // Reset with samples buffered
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 16'(16'h300 + i), 0, 0, 0);
    step(1, 0, 0, 16'h304, 0, 0, 0);
    step(1, 0, 0, 16'h305, 0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0, 1);
    chk("mrst_tvalid", 32'(m_tvalid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_unf", 32'(underflow), 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0, 1, 0, 0);
    chk("mrst_nostale", 32'(m_tvalid), 0);

    // Counter saturation
    step(1, 0, 0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 90; i++)
      step(1, 1, 0, 16'($urandom), 1, 0, 0);
    chk("cnt_sat", 32'(sample_cnt), 32'((1 << CW) - 1));

    // Randomized traffic
    en_r = 1'b1;
    dn_r = 1'b0;
    rb   = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = !en_r;
      if ($urandom_range(0, 29) == 0) dn_r = !dn_r;
      if ($urandom_range(0, 49) == 0) rb = $urandom_range(0, 3);
      step(en_r, 1'($urandom_range(0, 1)), dn_r, 16'($urandom),
           (rb == 0) ? 1'b0 :
           (rb == 3) ? 1'b1 : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 399) == 0),
           1'($urandom_range(0, 799) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
